// File: rtl/lc3b_types.sv
// Shared types for the LC-3b L2 cache: way index, L2 control FSM states,
// per-way status from the datapath and per-way control strobes to it.
// Helper functions map a way number onto the wayN fields of those structs.
package lc3b_types;

   typedef logic [2:0] lc3b_c_way;

   typedef enum logic [1:0] {
      l2_idle,
      l2_writeback,
      l2_fill
   } lc3b_l2_fsm_state;

   // Status of one way as seen by the control FSM.
   typedef struct packed {
      logic hit;
      logic d_out;
   } lc3b_l2_way_state;

   typedef struct packed {
      lc3b_l2_way_state way7;
      lc3b_l2_way_state way6;
      lc3b_l2_way_state way5;
      lc3b_l2_way_state way4;
      lc3b_l2_way_state way3;
      lc3b_l2_way_state way2;
      lc3b_l2_way_state way1;
      lc3b_l2_way_state way0;
   } lc3b_L2_state;

   // Load strobes and write values for one way's tag/data, valid and dirty bits.
   typedef struct packed {
      logic load_d;
      logic load_v;
      logic load_TD;
      logic d_in;
      logic v_in;
   } lc3b_l2_way_ctl;

   typedef struct packed {
      logic           load_lru;
      lc3b_l2_way_ctl way7;
      lc3b_l2_way_ctl way6;
      lc3b_l2_way_ctl way5;
      lc3b_l2_way_ctl way4;
      lc3b_l2_way_ctl way3;
      lc3b_l2_way_ctl way2;
      lc3b_l2_way_ctl way1;
      lc3b_l2_way_ctl way0;
   } lc3b_L2_ctl;

   // Gather the eight hit bits, bit N = wayN.hit.
   function automatic logic [7:0] state_hits(input lc3b_L2_state s);
      return {s.way7.hit, s.way6.hit, s.way5.hit, s.way4.hit,
              s.way3.hit, s.way2.hit, s.way1.hit, s.way0.hit};
   endfunction

   // Select the status of way n.
   function automatic lc3b_l2_way_state way_state(input lc3b_L2_state s,
                                                  input lc3b_c_way    n);
      lc3b_l2_way_state w;
      case (n)
         3'd0:    w = s.way0;
         3'd1:    w = s.way1;
         3'd2:    w = s.way2;
         3'd3:    w = s.way3;
         3'd4:    w = s.way4;
         3'd5:    w = s.way5;
         3'd6:    w = s.way6;
         default: w = s.way7;
      endcase
      return w;
   endfunction

   // Return c with way n's control replaced by w.
   function automatic lc3b_L2_ctl ctl_set_way(input lc3b_L2_ctl     c,
                                              input lc3b_c_way      n,
                                              input lc3b_l2_way_ctl w);
      lc3b_L2_ctl r;
      r = c;
      case (n)
         3'd0:    r.way0 = w;
         3'd1:    r.way1 = w;
         3'd2:    r.way2 = w;
         3'd3:    r.way3 = w;
         3'd4:    r.way4 = w;
         3'd5:    r.way5 = w;
         3'd6:    r.way6 = w;
         default: r.way7 = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/l2_hit_encoder.sv
// Purpose: reduce 8 per-way hit bits to hit_any plus lowest-index hit_idx.
// Latency: purely combinational. Backpressure: none.
// Ports: hit[7:0] in; hit_any out (OR of hit); hit_idx[2:0] out (lowest set bit,
// 0 when no hit). Multiple hits are illegal upstream but resolve to the lowest.
module l2_hit_encoder
   import lc3b_types::*;
(
   input  logic [7:0] hit,
   output logic       hit_any,
   output lc3b_c_way  hit_idx
);

   always_comb begin
      hit_any = |hit;
      hit_idx = '0;
      // Scan downward so the lowest set index is the last assignment.
      for (int i = 7; i >= 0; i--) begin
         if (hit[i]) begin
            hit_idx = 3'(i);
         end
      end
   end

endmodule

// File: rtl/l2_cache_control.sv
// Purpose: control FSM for the 8-way L2; sequences hits, clean-miss fill and
// dirty-victim writeback+fill. Latency: hit 0 wait states; miss 1 + W + F + 1.
// Backpressure: upstream holds mem_read/mem_write until mem_resp; pmem_* held until pmem_resp.
// Ports: clk, rst (sync, active-high); mem_read/mem_write in, mem_resp out;
// state (per-way hit/d_out) and lru_way in from the datapath; ctl, way_sel,
// datain_sel, pmem_addr_sel out to the datapath; pmem_read/pmem_write out,
// pmem_resp in to physical memory.
module l2_cache_control
   import lc3b_types::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         mem_read,
   input  logic         mem_write,
   output logic         mem_resp,
   input  lc3b_L2_state state,
   input  lc3b_c_way    lru_way,
   output lc3b_L2_ctl   ctl,
   output lc3b_c_way    way_sel,
   output logic         datain_sel,
   output logic         pmem_addr_sel,
   output logic         pmem_read,
   output logic         pmem_write,
   input  logic         pmem_resp
);

   lc3b_l2_fsm_state fsm;
   lc3b_l2_fsm_state fsm_next;
   lc3b_c_way        victim;
   logic             victim_cap;
   logic             req;
   logic             hit_any;
   lc3b_c_way        hit_idx;
   lc3b_l2_way_ctl   way_ctl;

   assign req = mem_read | mem_write;

   l2_hit_encoder u_hit_enc (
      .hit     (state_hits(state)),
      .hit_any (hit_any),
      .hit_idx (hit_idx)
   );

   // The victim is latched on the miss cycle so a pseudo-LRU update elsewhere
   // cannot retarget an in-flight writeback or fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm    <= l2_idle;
         victim <= '0;
      end else begin
         fsm <= fsm_next;
         if (victim_cap) begin
            victim <= lru_way;
         end
      end
   end

   always_comb begin
      fsm_next      = fsm;
      victim_cap    = 1'b0;
      mem_resp      = 1'b0;
      ctl           = '0;
      way_sel       = '0;
      datain_sel    = 1'b0;
      pmem_addr_sel = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      way_ctl       = '0;

      // Outputs are forced quiet during reset so a pmem_resp coinciding with
      // reset cannot install a line.
      if (!rst) begin
         case (fsm)
            l2_idle: begin
               if (req) begin
                  if (hit_any) begin
                     mem_resp     = 1'b1;
                     way_sel      = hit_idx;
                     ctl.load_lru = 1'b1;
                     // A simultaneous read and write is served as a write.
                     if (mem_write) begin
                        way_ctl.load_TD = 1'b1;
                        way_ctl.load_d  = 1'b1;
                        way_ctl.d_in    = 1'b1;
                        ctl             = ctl_set_way(ctl, hit_idx, way_ctl);
                     end
                  end else begin
                     victim_cap = 1'b1;
                     if (way_state(state, lru_way).d_out) begin
                        fsm_next = l2_writeback;
                     end else begin
                        fsm_next = l2_fill;
                     end
                  end
               end
            end

            l2_writeback: begin
               pmem_write    = 1'b1;
               pmem_addr_sel = 1'b1;
               way_sel       = victim;
               if (pmem_resp) begin
                  fsm_next = l2_fill;
               end
            end

            l2_fill: begin
               pmem_read  = 1'b1;
               way_sel    = victim;
               datain_sel = 1'b1;
               if (pmem_resp) begin
                  // Install clean and valid; the returning IDLE cycle then hits.
                  way_ctl.load_TD = 1'b1;
                  way_ctl.load_v  = 1'b1;
                  way_ctl.v_in    = 1'b1;
                  way_ctl.load_d  = 1'b1;
                  way_ctl.d_in    = 1'b0;
                  ctl             = ctl_set_way(ctl, victim, way_ctl);
                  fsm_next        = l2_idle;
               end
            end

            default: begin
               fsm_next = l2_idle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control: inputs change 2 time units after each
// rising edge, outputs are sampled 1 unit later, well before the next edge.
module tb_l2_cache_control;
   import lc3b_types::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read;
   logic         mem_write;
   logic         mem_resp;
   lc3b_L2_state st;
   lc3b_c_way    lru_way;
   lc3b_L2_ctl   ctl;
   lc3b_c_way    way_sel;
   logic         datain_sel;
   logic         pmem_addr_sel;
   logic         pmem_read;
   logic         pmem_write;
   logic         pmem_resp;

   int checks = 0;
   int errors = 0;

   lc3b_L2_ctl     e_ctl;
   lc3b_l2_way_ctl fill_w;
   lc3b_l2_way_ctl wr_w;

   always #5 clk = ~clk;

   l2_cache_control dut (
      .clk           (clk),
      .rst           (rst),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_resp      (mem_resp),
      .state         (st),
      .lru_way       (lru_way),
      .ctl           (ctl),
      .way_sel       (way_sel),
      .datain_sel    (datain_sel),
      .pmem_addr_sel (pmem_addr_sel),
      .pmem_read     (pmem_read),
      .pmem_write    (pmem_write),
      .pmem_resp     (pmem_resp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check every output against expectations.
   task automatic chk_all(input string tag, input logic e_resp, input lc3b_L2_ctl ec,
                          input logic [2:0] e_way, input logic e_dsel, input logic e_asel,
                          input logic e_pr, input logic e_pw);
      chk({tag, ".mem_resp"},      64'(mem_resp),      64'(e_resp));
      chk({tag, ".ctl"},           64'(ctl),           64'(ec));
      chk({tag, ".way_sel"},       64'(way_sel),       64'(e_way));
      chk({tag, ".datain_sel"},    64'(datain_sel),    64'(e_dsel));
      chk({tag, ".pmem_addr_sel"}, 64'(pmem_addr_sel), 64'(e_asel));
      chk({tag, ".pmem_read"},     64'(pmem_read),     64'(e_pr));
      chk({tag, ".pmem_write"},    64'(pmem_write),    64'(e_pw));
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      fill_w = '0;
      fill_w.load_TD = 1'b1;
      fill_w.load_v  = 1'b1;
      fill_w.v_in    = 1'b1;
      fill_w.load_d  = 1'b1;
      wr_w = '0;
      wr_w.load_TD = 1'b1;
      wr_w.load_d  = 1'b1;
      wr_w.d_in    = 1'b1;

      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; st = '0; lru_way = 3'd0; pmem_resp = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick(); settle();
      // Reset then idle.
      chk_all("reset", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.fsm",    64'(dut.fsm),    64'(l2_idle));
      chk("reset.victim", 64'(dut.victim), 64'd0);

      // Stray pmem_resp in IDLE is ignored.
      pmem_resp = 1'b1; settle();
      chk_all("idle_resp", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); pmem_resp = 1'b0; settle();
      chk("idle_resp.fsm", 64'(dut.fsm), 64'(l2_idle));

      // Read hit on way 5.
      st = '0; st.way5.hit = 1'b1; mem_read = 1'b1; settle();
      e_ctl = '0; e_ctl.load_lru = 1'b1;
      chk_all("rd_hit", 1'b1, e_ctl, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); mem_read = 1'b0; st = '0; settle();
      chk_all("rd_hit_after", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Write hit on way 2.
      st.way2.hit = 1'b1; mem_write = 1'b1; settle();
      e_ctl = '0; e_ctl.load_lru = 1'b1; e_ctl.way2 = wr_w;
      chk_all("wr_hit", 1'b1, e_ctl, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); mem_write = 1'b0; st = '0;

      // Multi-hit resolves to lowest way (3 over 6).
      st.way6.hit = 1'b1; st.way3.hit = 1'b1; mem_read = 1'b1; settle();
      e_ctl = '0; e_ctl.load_lru = 1'b1;
      chk_all("multi_hit", 1'b1, e_ctl, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); mem_read = 1'b0; st = '0;

      // Read+write together on a way-7 hit is served as a write.
      st.way7.hit = 1'b1; mem_read = 1'b1; mem_write = 1'b1; settle();
      e_ctl = '0; e_ctl.load_lru = 1'b1; e_ctl.way7 = wr_w;
      chk_all("rw_hit", 1'b1, e_ctl, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); mem_read = 1'b0; mem_write = 1'b0; st = '0;

      // Clean miss into way 3; way 0 dirty must not matter.
      st.way0.d_out = 1'b1; lru_way = 3'd3; mem_read = 1'b1; settle();
      chk_all("cm_idle", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         tick(); settle();
         chk_all($sformatf("cm_fill%0d", c), 1'b0, '0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      tick(); pmem_resp = 1'b1; settle();
      e_ctl = '0; e_ctl.way3 = fill_w;
      chk_all("cm_fill4", 1'b0, e_ctl, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(); pmem_resp = 1'b0; st.way3.hit = 1'b1; settle();
      e_ctl = '0; e_ctl.load_lru = 1'b1;
      chk_all("cm_hit", 1'b1, e_ctl, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); mem_read = 1'b0; st = '0; settle();
      chk_all("cm_done", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Dirty miss: victim 6, lru_way moves to 1 mid-miss.
      lru_way = 3'd6; st.way6.d_out = 1'b1; st.way1.d_out = 1'b0; mem_write = 1'b1; settle();
      chk_all("dm_idle", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); lru_way = 3'd1; settle();
      chk_all("dm_wb1", 1'b0, '0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(); pmem_resp = 1'b1; settle();
      chk_all("dm_wb2", 1'b0, '0, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1);
      tick(); pmem_resp = 1'b0; settle();
      chk_all("dm_fill1", 1'b0, '0, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(); pmem_resp = 1'b1; settle();
      e_ctl = '0; e_ctl.way6 = fill_w;
      chk_all("dm_fill2", 1'b0, e_ctl, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(); pmem_resp = 1'b0; st = '0; st.way6.hit = 1'b1; settle();
      e_ctl = '0; e_ctl.load_lru = 1'b1; e_ctl.way6 = wr_w;
      chk_all("dm_hit", 1'b1, e_ctl, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); mem_write = 1'b0; st = '0;

      // Upstream drops req during FILL; line still installed, then idle.
      lru_way = 3'd2; mem_read = 1'b1; settle();
      tick(); mem_read = 1'b0; settle();
      chk_all("drop_fill1", 1'b0, '0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(); pmem_resp = 1'b1; settle();
      e_ctl = '0; e_ctl.way2 = fill_w;
      chk_all("drop_fill2", 1'b0, e_ctl, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(); pmem_resp = 1'b0; settle();
      chk_all("drop_idle", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("drop_idle.fsm", 64'(dut.fsm), 64'(l2_idle));

      // Reset during FILL at cycle 2.
      lru_way = 3'd4; mem_read = 1'b1; settle();
      tick(); settle();
      chk_all("rf_fill1", 1'b0, '0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(); rst = 1'b1; pmem_resp = 1'b1; settle();
      chk("rf_rstcyc.ctl", 64'(ctl), 64'd0);
      tick(); rst = 1'b0; pmem_resp = 1'b0; mem_read = 1'b0; settle();
      chk_all("rf_after", 1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rf_after.fsm",    64'(dut.fsm),    64'(l2_idle));
      chk("rf_after.victim", 64'(dut.victim), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
